// File: rtl/jam_search.sv
// jam_search: exhaustive job-assignment search over all N! permutations in
// lexicographic order, reporting the best total, its multiplicity and the first best permutation.
module jam_search #(
  parameter int N   = 8,
  parameter int CW  = 7,
  parameter int SW  = 10,
  parameter int MCW = 16
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           START,
  input  logic           MODE,
  output logic [2:0]     W,
  output logic [2:0]     J,
  input  logic [CW-1:0]  Cost,
  output logic           BUSY,
  output logic           Valid,
  output logic [SW-1:0]  BestCost,
  output logic [MCW-1:0] MatchCount,
  output logic [3*N-1:0] BestPerm
);
  typedef enum logic [1:0] {IDLE, ACC, EVAL, DONE} state_t;

  state_t         r_state;
  logic           r_mode, r_first, r_busy, r_valid;
  logic [2:0]     r_k, r_w, r_j;
  logic [SW-1:0]  r_acc, r_best, r_best_out;
  logic [MCW-1:0] r_count, r_count_out;
  logic [3*N-1:0] r_perm, r_bperm, r_bperm_out;

  logic [3*N-1:0] w_ident, w_swap, w_next, w_bperm_n;
  logic           w_last, w_better, w_equal;
  logic [2:0]     w_pval, w_sval, w_jnext;
  int             w_piv, w_swp;
  logic [SW-1:0]  w_best_n;
  logic [MCW-1:0] w_count_n;

  always_comb begin
    for (int i = 0; i < N; i++) w_ident[3*i +: 3] = 3'(i);
  end

  // Next permutation: rightmost ascent is the pivot, swap it with the rightmost larger
  // element of the (descending) suffix, then reverse that suffix. No ascent means last one.
  always_comb begin
    w_last = 1'b1;
    w_piv  = 0;
    for (int i = 0; i < N-1; i++)
      if (r_perm[3*i +: 3] < r_perm[3*(i+1) +: 3]) begin
        w_piv  = i;
        w_last = 1'b0;
      end
    w_pval = '0;
    for (int i = 0; i < N; i++) if (i == w_piv) w_pval = r_perm[3*i +: 3];
    w_swp = w_piv;
    for (int i = 0; i < N; i++) if (i > w_piv && r_perm[3*i +: 3] > w_pval) w_swp = i;
    w_sval = '0;
    for (int i = 0; i < N; i++) if (i == w_swp) w_sval = r_perm[3*i +: 3];
    for (int i = 0; i < N; i++)
      w_swap[3*i +: 3] = (i == w_piv) ? w_sval : (i == w_swp) ? w_pval : r_perm[3*i +: 3];
    w_next = w_swap;
    for (int i = 0; i < N; i++)
      for (int m = 0; m < N; m++)
        if (i > w_piv && m == N + w_piv - i) w_next[3*i +: 3] = w_swap[3*m +: 3];
  end

  always_comb begin
    w_jnext = '0;
    for (int i = 0; i < N; i++) if (3'(i) == r_k + 3'd1) w_jnext = r_perm[3*i +: 3];
  end

  // The first permutation always wins so best/count never compare against stale values.
  always_comb begin
    w_equal   = (r_acc == r_best);
    w_better  = r_first || (r_mode ? (r_acc > r_best) : (r_acc < r_best));
    w_best_n  = r_best;
    w_count_n = r_count;
    w_bperm_n = r_bperm;
    if (w_better) begin
      w_best_n  = r_acc;
      w_count_n = MCW'(1);
      w_bperm_n = r_perm;
    end else if (w_equal && r_count != '1) begin
      w_count_n = r_count + MCW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= IDLE;
      r_mode      <= 1'b0;
      r_first     <= 1'b0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_k         <= '0;
      r_w         <= '0;
      r_j         <= '0;
      r_acc       <= '0;
      r_best      <= '0;
      r_count     <= '0;
      r_perm      <= w_ident;
      r_bperm     <= w_ident;
      r_best_out  <= '0;
      r_count_out <= '0;
      r_bperm_out <= w_ident;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: if (START) begin
          r_mode  <= MODE;
          r_perm  <= w_ident;
          r_k     <= '0;
          r_acc   <= '0;
          r_first <= 1'b1;
          r_busy  <= 1'b1;
          r_w     <= '0;
          r_j     <= '0;
          r_state <= ACC;
        end
        ACC: begin
          r_acc <= r_acc + SW'(Cost);
          if (r_k == 3'(N-1)) begin
            r_w     <= '0;
            r_j     <= '0;
            r_state <= EVAL;
          end else begin
            r_k <= r_k + 3'd1;
            r_w <= r_k + 3'd1;
            r_j <= w_jnext;
          end
        end
        EVAL: begin
          r_first <= 1'b0;
          r_best  <= w_best_n;
          r_count <= w_count_n;
          r_bperm <= w_bperm_n;
          if (w_last) begin
            r_best_out  <= w_best_n;
            r_count_out <= w_count_n;
            r_bperm_out <= w_bperm_n;
            r_valid     <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_perm  <= w_next;
            r_k     <= '0;
            r_acc   <= '0;
            r_w     <= '0;
            r_j     <= w_next[2:0];
            r_state <= ACC;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign W          = r_w;
  assign J          = r_j;
  assign BUSY       = r_busy;
  assign Valid      = r_valid;
  assign BestCost   = r_best_out;
  assign MatchCount = r_count_out;
  assign BestPerm   = r_bperm_out;
endmodule

// File: tb/tb_jam_search.sv
// tb_jam_search: scoreboard bench for jam_search using an N=3 instance and an N=4
// instance with a 4-bit match counter; expectations come from a brute-force model.
module tb_jam_search;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start3 = 1'b0, mode3 = 1'b0, start4 = 1'b0, mode4 = 1'b0;
  logic [2:0]  w3, j3, w4, j4;
  logic [6:0]  cost3, cost4;
  logic        busy3, valid3, busy4, valid4;
  logic [9:0]  best3, best4;
  logic [15:0] cnt3;
  logic [3:0]  cnt4;
  logic [8:0]  perm3;
  logic [11:0] perm4;

  int mtab[4][4];
  int nvec = 0;
  int nmis = 0;

  typedef struct {
    int          cost;
    int          count;
    logic [11:0] perm;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t last;

  always #5 clk = ~clk;

  assign cost3 = 7'(mtab[w3[1:0]][j3[1:0]]);
  assign cost4 = 7'(mtab[w4[1:0]][j4[1:0]]);

  jam_search #(.N(3), .CW(7), .SW(10), .MCW(16)) u3 (
    .CLK(clk), .RST_N(rst_n), .START(start3), .MODE(mode3), .W(w3), .J(j3), .Cost(cost3),
    .BUSY(busy3), .Valid(valid3), .BestCost(best3), .MatchCount(cnt3), .BestPerm(perm3)
  );

  jam_search #(.N(4), .CW(7), .SW(10), .MCW(4)) u4 (
    .CLK(clk), .RST_N(rst_n), .START(start4), .MODE(mode4), .W(w4), .J(j4), .Cost(cost4),
    .BUSY(busy4), .Valid(valid4), .BestCost(best4), .MatchCount(cnt4), .BestPerm(perm4)
  );

  function automatic logic obs_valid(input int n); return (n == 3) ? valid3 : valid4; endfunction
  function automatic logic obs_busy(input int n);  return (n == 3) ? busy3 : busy4;   endfunction
  function automatic int   obs_cost(input int n);  return (n == 3) ? int'(best3) : int'(best4); endfunction
  function automatic int   obs_count(input int n); return (n == 3) ? int'(cnt3) : int'(cnt4);   endfunction
  function automatic logic [11:0] obs_perm(input int n);
    return (n == 3) ? {3'd0, perm3} : perm4;
  endfunction
  function automatic logic [2:0] obs_w(input int n); return (n == 3) ? w3 : w4; endfunction
  function automatic logic [2:0] obs_j(input int n); return (n == 3) ? j3 : j4; endfunction

  // Brute force over all n^n index tuples, keeping only permutations, in lexicographic order.
  function automatic exp_t model(input int n, input bit mode);
    exp_t e;
    int   d[4];
    int   v, tot, sat, lim;
    bit   ok, first;
    sat = (n == 3) ? 65535 : 15;
    lim = 1;
    for (int i = 0; i < n; i++) lim *= n;
    e.cost = 0; e.count = 0; e.perm = '0; first = 1'b1;
    for (int i = 0; i < 4; i++) d[i] = 0;
    for (int idx = 0; idx < lim; idx++) begin
      v = idx;
      for (int p = n-1; p >= 0; p--) begin d[p] = v % n; v = v / n; end
      ok = 1'b1;
      for (int a = 0; a < n; a++) for (int b = 0; b < a; b++) if (d[a] == d[b]) ok = 1'b0;
      if (ok) begin
        tot = 0;
        for (int w = 0; w < n; w++) tot += mtab[w][d[w]];
        if (first || (mode ? (tot > e.cost) : (tot < e.cost))) begin
          e.cost = tot; e.count = 1; e.perm = '0; first = 1'b0;
          for (int w = 0; w < n; w++) e.perm[3*w +: 3] = 3'(d[w]);
        end else if (tot == e.cost && e.count < sat) begin
          e.count++;
        end
      end
    end
    e.cyc = ((n == 3) ? 6 : 24) * (n + 1) + 1;
    return e;
  endfunction

  task automatic set_table(input int kind);
    for (int w = 0; w < 4; w++)
      for (int j = 0; j < 4; j++)
        case (kind)
          0: mtab[w][j] = 0;
          1: mtab[w][j] = w * 3 + j;
          2: mtab[w][j] = (w == j) ? 0 : 10;
          default: mtab[w][j] = ((w == 0 && j == 2) || (w == 1 && j == 0) || (w == 2 && j == 1)) ? 1 : 9;
        endcase
  endtask

  task automatic kick(input int n, input bit mode);
    @(negedge clk);
    if (n == 3) begin start3 = 1'b1; mode3 = mode; end
    else        begin start4 = 1'b1; mode4 = mode; end
    @(posedge clk); #1;
    start3 = 1'b0;
    start4 = 1'b0;
  endtask

  // Runs one search; optionally checks the first W/J walk, or re-pulses START mid-search.
  task automatic run_search(input int n, input bit mode, input string tag, input bit chk_wj, input int poke);
    exp_t e, got;
    int   ed;
    bit   seen;
    e = model(n, mode);
    sb.push_back(e);
    kick(n, mode);
    nvec++;
    if (obs_busy(n) !== 1'b1) begin
      nmis++; $display("[TB] FAIL %s busy_on_start: got %b want 1", tag, obs_busy(n));
    end
    ed = 0; seen = 1'b0;
    while (!seen && ed < 2000) begin
      if (chk_wj && ed < n) begin
        nvec++;
        if (obs_w(n) !== 3'(ed) || obs_j(n) !== 3'(ed)) begin
          nmis++; $display("[TB] FAIL %s wj_step%0d: got W=%0d J=%0d want W=%0d J=%0d",
                           tag, ed, obs_w(n), obs_j(n), ed, ed);
        end
      end
      if (poke > 0 && ed == poke) begin
        nvec++;
        if (obs_cost(n) !== last.cost || obs_count(n) !== last.count) begin
          nmis++; $display("[TB] FAIL %s held_results: got cost=%0d cnt=%0d want cost=%0d cnt=%0d",
                           tag, obs_cost(n), obs_count(n), last.cost, last.count);
        end
        if (n == 3) begin start3 = 1'b1; mode3 = ~mode; end
        else        begin start4 = 1'b1; mode4 = ~mode; end
        @(posedge clk); #1; ed++;
        start3 = 1'b0; start4 = 1'b0;
      end
      if (obs_valid(n)) seen = 1'b1;
      else begin @(posedge clk); #1; ed++; end
    end
    got = sb.pop_front();
    nvec++;
    if (!seen) begin
      nmis++; $display("[TB] FAIL %s valid_timeout: got none want cycle %0d", tag, got.cyc);
    end else begin
      if (ed + 1 !== got.cyc) begin
        nmis++; $display("[TB] FAIL %s latency: got cycle %0d want %0d", tag, ed + 1, got.cyc);
      end
      nvec += 3;
      if (obs_cost(n) !== got.cost) begin
        nmis++; $display("[TB] FAIL %s best_cost: got %0d want %0d", tag, obs_cost(n), got.cost);
      end
      if (obs_count(n) !== got.count) begin
        nmis++; $display("[TB] FAIL %s match_count: got %0d want %0d", tag, obs_count(n), got.count);
      end
      if (obs_perm(n) !== got.perm) begin
        nmis++; $display("[TB] FAIL %s best_perm: got %h want %h", tag, obs_perm(n), got.perm);
      end
    end
    last = got;
    @(posedge clk); #1;
    nvec++;
    if (obs_valid(n) !== 1'b0 || obs_busy(n) !== 1'b0) begin
      nmis++; $display("[TB] FAIL %s after_done: got valid=%b busy=%b want 0 0", tag, obs_valid(n), obs_busy(n));
    end
    if (poke > 0) begin
      repeat (40) begin
        @(posedge clk); #1;
        nvec++;
        if (obs_valid(n) !== 1'b0 || obs_busy(n) !== 1'b0) begin
          nmis++; $display("[TB] FAIL %s spurious_run: got valid=%b busy=%b want 0 0",
                           tag, obs_valid(n), obs_busy(n));
        end
      end
    end
  endtask

  task automatic test_reset();
    nvec += 7;
    if (best3 !== 10'd0 || best4 !== 10'd0) begin
      nmis++; $display("[TB] FAIL reset_cost: got %0d/%0d want 0/0", best3, best4);
    end
    if (cnt3 !== 16'd0 || cnt4 !== 4'd0) begin
      nmis++; $display("[TB] FAIL reset_count: got %0d/%0d want 0/0", cnt3, cnt4);
    end
    if (perm3 !== 9'b010_001_000) begin
      nmis++; $display("[TB] FAIL reset_perm3: got %b want 010001000", perm3);
    end
    if (perm4 !== 12'b011_010_001_000) begin
      nmis++; $display("[TB] FAIL reset_perm4: got %b want 011010001000", perm4);
    end
    if (busy3 !== 1'b0 || busy4 !== 1'b0) begin
      nmis++; $display("[TB] FAIL reset_busy: got %b/%b want 0/0", busy3, busy4);
    end
    if (valid3 !== 1'b0 || valid4 !== 1'b0) begin
      nmis++; $display("[TB] FAIL reset_valid: got %b/%b want 0/0", valid3, valid4);
    end
    if (w3 !== 3'd0 || j3 !== 3'd0 || w4 !== 3'd0 || j4 !== 3'd0) begin
      nmis++; $display("[TB] FAIL reset_wj: got %0d %0d %0d %0d want 0 0 0 0", w3, j3, w4, j4);
    end
  endtask

  task automatic test_sum_table();
    set_table(1);
    run_search(3, 1'b0, "sum_min", 1'b1, 0);
    run_search(3, 1'b1, "sum_max", 1'b0, 0);
  endtask

  task automatic test_unique_min();
    set_table(3);
    run_search(3, 1'b0, "unique_min", 1'b1, 0);
  endtask

  task automatic test_start_ignored();
    set_table(1);
    run_search(3, 1'b1, "start_ignored", 1'b0, 10);
  endtask

  task automatic test_start_held();
    exp_t e, got;
    int   ed, nv;
    int   ev[2];
    set_table(3);
    e = model(3, 1'b1);
    sb.push_back(e);
    sb.push_back(e);
    @(negedge clk); start3 = 1'b1; mode3 = 1'b1;
    @(posedge clk); #1;
    ed = 0; nv = 0; ev[0] = 0; ev[1] = 0;
    while (nv < 2 && ed < 400) begin
      @(posedge clk); #1; ed++;
      if (valid3) begin
        ev[nv] = ed; nv++;
        if (nv == 2) start3 = 1'b0;
        got = sb.pop_front();
        nvec += 2;
        if (int'(best3) !== got.cost || int'(cnt3) !== got.count) begin
          nmis++; $display("[TB] FAIL held_start_result%0d: got cost=%0d cnt=%0d want cost=%0d cnt=%0d",
                           nv, best3, cnt3, got.cost, got.count);
        end
        if ({3'd0, perm3} !== got.perm) begin
          nmis++; $display("[TB] FAIL held_start_perm%0d: got %h want %h", nv, perm3, got.perm);
        end
      end
    end
    start3 = 1'b0;
    nvec += 2;
    if (nv < 2) begin
      nmis++; $display("[TB] FAIL held_start_timeout: got %0d valids want 2", nv);
      sb.delete();
    end else if (ev[1] - ev[0] !== 26) begin
      nmis++; $display("[TB] FAIL held_start_gap: got %0d want 26", ev[1] - ev[0]);
    end
    if (ev[0] + 1 !== e.cyc) begin
      nmis++; $display("[TB] FAIL held_start_latency: got cycle %0d want %0d", ev[0] + 1, e.cyc);
    end
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if (busy3 !== 1'b0) begin
      nmis++; $display("[TB] FAIL held_start_idle: got busy=%b want 0", busy3);
    end
  endtask

  task automatic test_diag();
    set_table(2);
    run_search(4, 1'b0, "diag_min", 1'b0, 0);
    run_search(4, 1'b1, "diag_max", 1'b0, 0);
  endtask

  task automatic test_saturation();
    set_table(0);
    run_search(4, 1'b0, "saturate", 1'b0, 0);
  endtask

  task automatic test_reset_mid();
    set_table(1);
    kick(3, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    nvec += 3;
    if (best3 !== 10'd0 || cnt3 !== 16'd0) begin
      nmis++; $display("[TB] FAIL midreset_results: got cost=%0d cnt=%0d want 0 0", best3, cnt3);
    end
    if (perm3 !== 9'b010_001_000) begin
      nmis++; $display("[TB] FAIL midreset_perm: got %b want 010001000", perm3);
    end
    if (busy3 !== 1'b0 || w3 !== 3'd0 || j3 !== 3'd0) begin
      nmis++; $display("[TB] FAIL midreset_busy_wj: got busy=%b W=%0d J=%0d want 0 0 0", busy3, w3, j3);
    end
    repeat (3) begin
      @(posedge clk); #1;
      nvec++;
      if (valid3 !== 1'b0) begin
        nmis++; $display("[TB] FAIL midreset_valid: got %b want 0", valid3);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (30) begin
      @(posedge clk); #1;
      nvec++;
      if (valid3 !== 1'b0 || busy3 !== 1'b0) begin
        nmis++; $display("[TB] FAIL midreset_quiet: got valid=%b busy=%b want 0 0", valid3, busy3);
      end
    end
    run_search(3, 1'b0, "after_reset", 1'b1, 0);
  endtask

  initial begin
    set_table(0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_sum_table();
    test_unique_min();
    test_start_ignored();
    test_start_held();
    test_diag();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
